tx_rate_limiter: RTL and testbench



---
 rtl/tx_rate_limiter.sv | 160 ++++++++++++++++
 tb/tb_tx_rate_limiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_rate_limiter.sv
// Token-bucket egress shaper: payload words 1 cycle, IOQ headers >=2 cycles (bucket compare happens in HOLD).
// in_rdy = out_rdy except in HOLD (0); stat counters exist only with TX_RATE_LIMITER_STATS_EN.
module tx_rate_limiter #(
  parameter int DATA_WIDTH     = 64,
  parameter int CTRL_WIDTH     = DATA_WIDTH/8,
  parameter int TOKEN_WIDTH    = 20,
  parameter int TOKEN_INTERVAL = 8,
  parameter int TOKEN_INC      = 8,
  parameter int BUCKET_MAX     = 4096,
  parameter logic [CTRL_WIDTH-1:0] IOQ_HDR_CTRL = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [31:0]           stat_pkts,
  output logic [31:0]           stat_stall_cycles
);

  localparam int SW = TOKEN_WIDTH + 2;
  localparam int CW = (TOKEN_INTERVAL > 1) ? $clog2(TOKEN_INTERVAL) : 1;
  localparam logic signed [SW-1:0] LP_MAX  = SW'(BUCKET_MAX);
  localparam logic signed [SW-1:0] LP_INC  = SW'(TOKEN_INC);
  localparam logic [CW-1:0]        LP_LAST = CW'(TOKEN_INTERVAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_PKT_HDR, S_PKT_DATA} state_t;

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_hold_data;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic [CTRL_WIDTH-1:0]  r_out_ctrl;
  logic                   r_out_wr;
  logic [TOKEN_WIDTH-1:0] r_tokens;
  logic [CW-1:0]          r_refill_cnt;

  logic                   w_xfer;
  logic                   w_refill;
  logic                   w_oversize;
  logic                   w_release;
  logic signed [SW-1:0]   w_tokens;
  logic signed [SW-1:0]   w_len;
  logic signed [SW-1:0]   w_sum;
  logic [TOKEN_WIDTH-1:0] w_tok_next;

  assign in_rdy   = (r_state != S_HOLD) && out_rdy;
  assign w_xfer   = in_wr && in_rdy;
  assign w_refill = (r_refill_cnt == LP_LAST);

  assign out_data = r_out_data;
  assign out_ctrl = r_out_ctrl;
  assign out_wr   = r_out_wr;

  // byte_len lives in the low 16 bits of the held IOQ header
  assign w_tokens   = SW'(r_tokens);
  assign w_len      = SW'(r_hold_data[15:0]);
  assign w_oversize = (w_len > LP_MAX);
  assign w_release  = (r_state == S_HOLD) && out_rdy &&
                      ((w_tokens >= w_len) || (w_oversize && (w_tokens == LP_MAX)));

  // refill and deduction resolve together; only an oversize packet can go negative
  assign w_sum = w_tokens + (w_refill ? LP_INC : '0) - (w_release ? w_len : '0);

  always_comb begin
    w_tok_next = w_sum[TOKEN_WIDTH-1:0];
    if (w_sum > LP_MAX) begin
      w_tok_next = LP_MAX[TOKEN_WIDTH-1:0];
    end else if (w_sum < 0) begin
      w_tok_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tokens     <= LP_MAX[TOKEN_WIDTH-1:0];
      r_refill_cnt <= '0;
    end else begin
      r_tokens     <= w_tok_next;
      r_refill_cnt <= w_refill ? '0 : r_refill_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_hold_data <= '0;
      r_out_data  <= '0;
      r_out_ctrl  <= '0;
      r_out_wr    <= 1'b0;
    end else begin
      r_out_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            if (in_ctrl == IOQ_HDR_CTRL) begin
              r_hold_data <= in_data;
              r_state     <= S_HOLD;
            end else begin
              r_out_data <= in_data;
              r_out_ctrl <= in_ctrl;
              r_out_wr   <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_release) begin
            r_out_data <= r_hold_data;
            r_out_ctrl <= IOQ_HDR_CTRL;
            r_out_wr   <= 1'b1;
            r_state    <= S_PKT_HDR;
          end
        end
        S_PKT_HDR: begin
          if (w_xfer) begin
            r_out_data <= in_data;
            r_out_ctrl <= in_ctrl;
            r_out_wr   <= 1'b1;
            if (in_ctrl == '0) r_state <= S_PKT_DATA;
          end
        end
        S_PKT_DATA: begin
          if (w_xfer) begin
            r_out_data <= in_data;
            r_out_ctrl <= in_ctrl;
            r_out_wr   <= 1'b1;
            if (in_ctrl != '0) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef TX_RATE_LIMITER_STATS_EN
  logic [31:0] r_stat_pkts;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_pkts  <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_release) r_stat_pkts <= r_stat_pkts + 32'd1;
      if ((r_state == S_HOLD) && !w_release) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_pkts         = r_stat_pkts;
  assign stat_stall_cycles = r_stat_stall;
`else
  assign stat_pkts         = '0;
  assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_tx_rate_limiter.sv
// Random/directed bench for tx_rate_limiter: cycle-level token-bucket reference plus an in-order scoreboard.
module tb_tx_rate_limiter;
  localparam int BMAX = 4096;
  localparam int INTV = 8;
  localparam int INC  = 8;
  localparam logic [7:0] HDR = 8'hFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic [31:0] stat_pkts;
  logic [31:0] stat_stall_cycles;

  always #5 clk = ~clk;

  tx_rate_limiter dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .stat_pkts(stat_pkts), .stat_stall_cycles(stat_stall_cycles)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } word_t;

  word_t src_q[$];
  word_t sb_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  // reference: 0 idle, 1 waiting for credit, 2 in module headers, 3 in payload
  int          m_mode;
  int          m_tok;
  int          m_edge;
  int          m_len;
  int unsigned m_pkts;
  int unsigned m_stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_tok   = BMAX;
    m_edge  = 0;
    m_len   = 0;
    m_pkts  = 0;
    m_stall = 0;
    sb_q.delete();
  endtask

  task automatic model_edge(input bit acc, input word_t w, input bit ordy, output bit exp_wr);
    bit rel;
    int tmp;
    exp_wr = 1'b0;
    rel = (m_mode == 1) && ordy && ((m_tok >= m_len) || ((m_len > BMAX) && (m_tok == BMAX)));
    if (acc) sb_q.push_back(w);
    case (m_mode)
      0: if (acc) begin
           if (w.c == HDR) begin m_mode = 1; m_len = int'(w.d[15:0]); end
           else exp_wr = 1'b1;
         end
      1: if (rel) begin exp_wr = 1'b1; m_mode = 2; m_pkts++; end
         else m_stall++;
      2: if (acc) begin exp_wr = 1'b1; if (w.c == 8'h00) m_mode = 3; end
      default: if (acc) begin exp_wr = 1'b1; if (w.c != 8'h00) m_mode = 0; end
    endcase
    tmp = m_tok + (((m_edge % INTV) == INTV - 1) ? INC : 0) - (rel ? m_len : 0);
    m_tok = (tmp > BMAX) ? BMAX : ((tmp < 0) ? 0 : tmp);
    m_edge++;
  endtask

  task automatic chk_stats();
`ifdef TX_RATE_LIMITER_STATS_EN
    chk("stat_pkts", 64'(stat_pkts), 64'(m_pkts));
    chk("stat_stall_cycles", 64'(stat_stall_cycles), 64'(m_stall));
`else
    chk("stat_pkts", 64'(stat_pkts), 64'd0);
    chk("stat_stall_cycles", 64'(stat_stall_cycles), 64'd0);
`endif
  endtask

  // called at posedge+1; drives one cycle, checks in_rdy, then checks the registered outputs
  task automatic run_cycle(input bit ordy, input bit want);
    bit    rdy, acc, exp_wr;
    word_t w;
    w = '0;
    out_rdy = ordy;
    rdy = (m_mode != 1) && ordy;
    acc = want && rdy && (src_q.size() > 0);
    if (acc) w = src_q.pop_front();
    in_wr   = acc;
    in_data = acc ? w.d : {$urandom, $urandom};
    in_ctrl = acc ? w.c : 8'($urandom);
    #1;
    chk("in_rdy", 64'(in_rdy), 64'(rdy));
    model_edge(acc, w, ordy, exp_wr);
    @(posedge clk);
    #1;
    chk("out_wr", 64'(out_wr), 64'(exp_wr));
    if (exp_wr && (sb_q.size() > 0)) begin
      w = sb_q.pop_front();
      chk("out_data", out_data, w.d);
      chk("out_ctrl", 64'(out_ctrl), 64'(w.c));
    end
    chk_stats();
  endtask

  task automatic push_pkt(input int blen, input int npay, input bit xhdr);
    word_t w;
    w.d = {16'($urandom), 16'($urandom), 16'($urandom), 16'(blen)};
    w.c = HDR;
    src_q.push_back(w);
    if (xhdr) begin
      w.d = {$urandom, $urandom}; w.c = 8'h3C; src_q.push_back(w);
    end
    for (int i = 0; i < npay; i++) begin
      w.d = {$urandom, $urandom}; w.c = 8'h00; src_q.push_back(w);
    end
    w.d = {$urandom, $urandom};
    w.c = 8'(1 << $urandom_range(0, 7));
    src_q.push_back(w);
  endtask

  // rmode: 0 out_rdy high, 1 toggle every cycle, 2 random
  task automatic drain(input int rmode, input int wantpct, input int budget, input string tag);
    int n;
    bit ordy;
    n = 0;
    while (((src_q.size() > 0) || (m_mode != 0) || (sb_q.size() > 0)) && (n < budget)) begin
      case (rmode)
        0: ordy = 1'b1;
        1: ordy = ((n % 2) == 0);
        default: ordy = ($urandom_range(0, 3) != 0);
      endcase
      run_cycle(ordy, $urandom_range(0, 99) < wantpct);
      n++;
    end
    chk({tag, "_done"}, 64'((src_q.size() == 0) && (m_mode == 0) && (sb_q.size() == 0)), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    n;
    word_t w;
    reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0; out_rdy = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_in_rdy_hi", 64'(in_rdy), 64'd1);
    out_rdy = 1'b0;
    #1;
    chk("rst_in_rdy_lo", 64'(in_rdy), 64'd0);
    chk_stats();
    out_rdy = 1'b1;
    reset = 1'b0;

    push_pkt(60, 6, 1'b0);
    drain(0, 100, 200, "pkt60");

    push_pkt(1514, 20, 1'b1);
    push_pkt(3000, 30, 1'b0);
    drain(0, 100, 2000, "b2b");

    // oversize empties the bucket, then the 64-byte header waits on refills
    push_pkt(5000, 4, 1'b0);
    push_pkt(64, 7, 1'b0);
    drain(0, 100, 6000, "oversize_drain");

    for (int p = 0; p < 20; p++) begin
      push_pkt($urandom_range(1, 400), $urandom_range(1, 8), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        w.d = {$urandom, $urandom}; w.c = 8'($urandom_range(0, 254)); src_q.push_back(w);
      end
    end
    drain(2, 70, 20000, "random");

    for (int p = 0; p < 6; p++) push_pkt($urandom_range(1, 200), $urandom_range(2, 10), 1'b0);
    drain(1, 100, 6000, "toggle");

    push_pkt(100, 12, 1'b0);
    n = 0;
    while ((m_mode != 3) && (n < 100)) begin run_cycle(1'b1, 1'b1); n++; end
    repeat (3) run_cycle(1'b1, 1'b1);
    in_wr = 1'b0;
    out_rdy = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_wr", 64'(out_wr), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("midrst_in_rdy", 64'(in_rdy), 64'd1);
    model_reset();
    chk_stats();
    @(posedge clk);
    #1 reset = 1'b0;
    // a 4000-byte header only releases at once if the bucket was refilled by reset
    push_pkt(4000, 5, 1'b0);
    drain(0, 100, 500, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
